// File: rtl/re_demapper.sv
// Receive resource-element demapper: picks the allocated subcarriers out of each
// bin-ordered FFT symbol and steers them to a DMRS stream or a data stream.
module re_demapper #(
    parameter int WIDTH        = 26,
    parameter int NFFT         = 2048,
    parameter int ADDR_W       = 11,
    parameter int SYM_PER_SLOT = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     slot_start,
    input  logic [ADDR_W-1:0]        N_sc_start,
    input  logic [6:0]               N_rb,
    input  logic [3:0]               Sym_Start,
    input  logic [3:0]               Sym_End,
    input  logic [3:0]               Dmrs_sym,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic signed [WIDTH-1:0]  in_r,
    input  logic signed [WIDTH-1:0]  in_i,
    output logic                     data_valid,
    output logic                     dmrs_valid,
    output logic signed [WIDTH-1:0]  out_r,
    output logic signed [WIDTH-1:0]  out_i,
    output logic [ADDR_W-1:0]        out_sc_idx,
    output logic [3:0]               out_sym,
    output logic                     sym_last,
    output logic                     slot_done,
    output logic                     cfg_err,
    output logic                     sync_err
);

    localparam int EXT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_SYM, RUN, DONE} state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] bin_cnt;
    logic [3:0]        sym_cnt;
    logic [ADDR_W-1:0] cfg_k0;
    logic [EXT_W-1:0]  cfg_m;
    logic [EXT_W-1:0]  cfg_end;
    logic [3:0]        cfg_sym_start;
    logic [3:0]        cfg_sym_end;
    logic [3:0]        cfg_dmrs_sym;
    logic              cfg_err_q;
    logic              sync_err_q;

    logic [EXT_W-1:0]  m_in;
    logic [EXT_W-1:0]  end_in;
    logic              accept;
    logic              restart;
    logic [ADDR_W-1:0] bin;
    logic              sym_end_hit;
    logic              slot_end;
    logic [ADDR_W-1:0] sc_off;
    logic              sel;
    logic              is_dmrs;
    logic              is_last;

    logic                    data_vld_p1;
    logic                    dmrs_vld_p1;
    logic                    last_p1;
    logic signed [WIDTH-1:0] r_p1;
    logic signed [WIDTH-1:0] i_p1;
    logic [ADDR_W-1:0]       idx_p1;
    logic [3:0]              sym_p1;

    // End bin is computed one bit wider so an over-range allocation cannot wrap.
    function automatic logic cfg_bad(input logic [6:0] nrb, input logic [EXT_W-1:0] end_bin,
                                     input logic [3:0] s_start, input logic [3:0] s_end);
        return (nrb == 7'd0) || (end_bin > EXT_W'(NFFT)) ||
               (s_start > s_end) || (s_end >= 4'(SYM_PER_SLOT));
    endfunction

    assign m_in   = EXT_W'(N_rb) * EXT_W'(12);
    assign end_in = EXT_W'(N_sc_start) + m_in;

    // A leading in_first always maps the sample to bin 0, mid-symbol ones included.
    always_comb begin
        accept  = 1'b0;
        restart = 1'b0;
        bin     = bin_cnt;
        if (!slot_start && in_valid) begin
            case (state)
                WAIT_SYM: begin
                    if (in_first) begin
                        accept = 1'b1;
                        bin    = '0;
                    end
                end
                RUN: begin
                    accept = 1'b1;
                    if (in_first) begin
                        bin     = '0;
                        restart = (bin_cnt != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sym_end_hit = accept && (bin == ADDR_W'(NFFT - 1));
    assign slot_end    = sym_end_hit && (sym_cnt == 4'(SYM_PER_SLOT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (slot_start) begin
            next_state = WAIT_SYM;
        end else begin
            case (state)
                WAIT_SYM, RUN: begin
                    if (accept) begin
                        if (slot_end)         next_state = DONE;
                        else if (sym_end_hit) next_state = WAIT_SYM;
                        else                  next_state = RUN;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        slot_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_cnt       <= '0;
            sym_cnt       <= '0;
            cfg_k0        <= '0;
            cfg_m         <= '0;
            cfg_end       <= '0;
            cfg_sym_start <= '0;
            cfg_sym_end   <= '0;
            cfg_dmrs_sym  <= '0;
            cfg_err_q     <= 1'b0;
            sync_err_q    <= 1'b0;
        end else if (slot_start) begin
            bin_cnt       <= '0;
            sym_cnt       <= '0;
            cfg_k0        <= N_sc_start;
            cfg_m         <= m_in;
            cfg_end       <= end_in;
            cfg_sym_start <= Sym_Start;
            cfg_sym_end   <= Sym_End;
            cfg_dmrs_sym  <= Dmrs_sym;
            cfg_err_q     <= cfg_bad(N_rb, end_in, Sym_Start, Sym_End);
            sync_err_q    <= 1'b0;
        end else if (accept) begin
            if (restart) sync_err_q <= 1'b1;
            if (sym_end_hit) begin
                bin_cnt <= '0;
                if (!slot_end) sym_cnt <= sym_cnt + 4'd1;
            end else begin
                bin_cnt <= bin + ADDR_W'(1);
            end
        end
    end

    assign sc_off  = bin - cfg_k0;
    assign is_dmrs = (sym_cnt == cfg_dmrs_sym);
    assign is_last = ({1'b0, sc_off} == cfg_m - EXT_W'(1));
    assign sel     = accept && !cfg_err_q &&
                     ({1'b0, bin} >= {1'b0, cfg_k0}) && ({1'b0, bin} < cfg_end) &&
                     (sym_cnt >= cfg_sym_start) && (sym_cnt <= cfg_sym_end);

    // Stage p1: registered outputs; sample fields hold while nothing is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_vld_p1 <= 1'b0;
            dmrs_vld_p1 <= 1'b0;
            last_p1     <= 1'b0;
            r_p1        <= '0;
            i_p1        <= '0;
            idx_p1      <= '0;
            sym_p1      <= '0;
        end else begin
            data_vld_p1 <= sel && !is_dmrs;
            dmrs_vld_p1 <= sel && is_dmrs;
            last_p1     <= sel && is_last;
            if (sel) begin
                r_p1   <= in_r;
                i_p1   <= in_i;
                idx_p1 <= sc_off;
                sym_p1 <= sym_cnt;
            end
        end
    end

    assign data_valid = data_vld_p1;
    assign dmrs_valid = dmrs_vld_p1;
    assign sym_last   = last_p1;
    assign out_r      = r_p1;
    assign out_i      = i_p1;
    assign out_sc_idx = idx_p1;
    assign out_sym    = sym_p1;
    assign cfg_err    = cfg_err_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_re_demapper.sv
// Bench for re_demapper: directed slots driven against an allocation model that
// predicts every output cycle, plus literal counts for each scenario.
module tb_re_demapper;

    localparam int WIDTH = 26;
    localparam int NFFT  = 2048;
    localparam int NSYM  = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset, slot_start, in_valid, in_first;
    logic [10:0]             N_sc_start;
    logic [6:0]              N_rb;
    logic [3:0]              Sym_Start, Sym_End, Dmrs_sym;
    logic signed [WIDTH-1:0] in_r, in_i;
    logic                    data_valid, dmrs_valid, sym_last, slot_done, cfg_err, sync_err;
    logic signed [WIDTH-1:0] out_r, out_i;
    logic [10:0]             out_sc_idx;
    logic [3:0]              out_sym;

    re_demapper dut (
        .clk(clk), .reset(reset), .slot_start(slot_start),
        .N_sc_start(N_sc_start), .N_rb(N_rb), .Sym_Start(Sym_Start), .Sym_End(Sym_End),
        .Dmrs_sym(Dmrs_sym), .in_valid(in_valid), .in_first(in_first),
        .in_r(in_r), .in_i(in_i), .data_valid(data_valid), .dmrs_valid(dmrs_valid),
        .out_r(out_r), .out_i(out_i), .out_sc_idx(out_sc_idx), .out_sym(out_sym),
        .sym_last(sym_last), .slot_done(slot_done), .cfg_err(cfg_err), .sync_err(sync_err)
    );

    typedef struct packed {
        logic dv, mv, last, done, cerr, serr;
        logic signed [WIDTH-1:0] r, i;
        logic [10:0] idx;
        logic [3:0]  sym;
    } exp_t;

    typedef struct packed {
        logic dm;
        logic [3:0] sym;
        logic [10:0] idx;
        logic signed [WIDTH-1:0] r;
    } rec_t;

    exp_t e_n, e_q;
    int   c_k0, c_m, c_ss, c_se, c_dm;
    bit   c_bad;
    int   vecs, fails;
    bit   chk_en;
    int   n_data, n_dmrs, n_done;
    rec_t rec_q[$];
    rec_t qb[$];
    int   last_q[$];

    // Expectation set up while driving a cycle applies to the outputs after its edge.
    always @(posedge clk) e_q <= e_n;

    always @(negedge clk) begin
        if (chk_en) begin
            vecs++;
            if ({data_valid, dmrs_valid, sym_last, slot_done, cfg_err, sync_err} !==
                {e_q.dv, e_q.mv, e_q.last, e_q.done, e_q.cerr, e_q.serr} ||
                out_r !== e_q.r || out_i !== e_q.i || out_sc_idx !== e_q.idx || out_sym !== e_q.sym) begin
                fails++;
                $display("FAIL cycle t=%0t: dv,mv,last,done,cerr,serr=%b%b%b%b%b%b want %b%b%b%b%b%b r=%0d want %0d i=%0d want %0d idx=%0d want %0d sym=%0d want %0d",
                         $time, data_valid, dmrs_valid, sym_last, slot_done, cfg_err, sync_err,
                         e_q.dv, e_q.mv, e_q.last, e_q.done, e_q.cerr, e_q.serr,
                         out_r, e_q.r, out_i, e_q.i, out_sc_idx, e_q.idx, out_sym, e_q.sym);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (data_valid) n_data++;
            if (dmrs_valid) n_dmrs++;
            if (slot_done)  n_done++;
            if (data_valid || dmrs_valid) rec_q.push_back({dmrs_valid, out_sym, out_sc_idx, out_r});
            if (sym_last) last_q.push_back(int'(out_r));
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        vecs++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic junk_cfg();
        N_sc_start = 11'd5; N_rb = 7'd0; Sym_Start = 4'd9; Sym_End = 4'd1; Dmrs_sym = 4'd0;
    endtask

    task automatic clear_pulses();
        e_n.dv = 1'b0; e_n.mv = 1'b0; e_n.last = 1'b0; e_n.done = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        reset = 1'b0; slot_start = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        in_r = '0; in_i = '0; junk_cfg();
        clear_pulses();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; slot_start = 1'b0; in_valid = 1'b1; in_first = 1'b0;
        in_r = 26'sd77; in_i = -26'sd77;
        e_n = '0;
    endtask

    task automatic do_start(input int k0, input int nrb, input int ss, input int se, input int dm);
        @(negedge clk);
        reset = 1'b0; slot_start = 1'b1;
        N_sc_start = 11'(k0); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se); Dmrs_sym = 4'(dm);
        in_valid = 1'b1; in_first = 1'b1; in_r = 26'sd12345; in_i = -26'sd1;
        c_k0 = k0; c_m = 12 * nrb; c_ss = ss; c_se = se; c_dm = dm;
        c_bad = (nrb == 0) || (k0 + 12 * nrb > NFFT) || (ss > se) || (se >= NSYM);
        clear_pulses();
        e_n.cerr = c_bad; e_n.serr = 1'b0;
    endtask

    // One input sample; acc says whether the block should take it as bin k of symbol l.
    task automatic samp(input bit first, input bit acc, input int l, input int k,
                        input bit fin, input bit serr);
        @(negedge clk);
        reset = 1'b0; slot_start = 1'b0; junk_cfg();
        in_valid = 1'b1; in_first = first;
        in_r = WIDTH'(k); in_i = WIDTH'(-(l * NFFT + k) - 1);
        clear_pulses();
        e_n.done = fin;
        if (serr) e_n.serr = 1'b1;
        if (acc && !c_bad && l >= c_ss && l <= c_se && k >= c_k0 && k < c_k0 + c_m) begin
            if (l == c_dm) e_n.mv = 1'b1;
            else           e_n.dv = 1'b1;
            e_n.last = (k - c_k0 == c_m - 1);
            e_n.r    = WIDTH'(k);
            e_n.i    = WIDTH'(-(l * NFFT + k) - 1);
            e_n.idx  = 11'(k - c_k0);
            e_n.sym  = 4'(l);
        end
    endtask

    task automatic run_slot(input bit gap, input int sync_sym, input int sync_bin,
                            input int stop_sym, input int stop_bin);
        int  kk;
        bit  synced;
        for (int l = 0; l < NSYM; l++) begin
            idle();
            samp(1'b0, 1'b0, l, 5, 1'b0, 1'b0);
            kk = 0;
            synced = 1'b0;
            while (kk < NFFT) begin
                if (l == stop_sym && kk == stop_bin) return;
                if (l == sync_sym && kk == sync_bin && !synced) begin
                    synced = 1'b1;
                    kk = 0;
                    samp(1'b1, 1'b1, l, 0, 1'b0, 1'b1);
                end else begin
                    samp(kk == 0, 1'b1, l, kk, (l == NSYM - 1) && (kk == NFFT - 1), 1'b0);
                end
                if (gap) idle();
                kk++;
            end
        end
    endtask

    initial begin
        int b_data, b_dmrs, b_done, bad;
        reset = 1'b1; slot_start = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        in_r = '0; in_i = '0; junk_cfg();
        e_n = '0; chk_en = 1'b0; vecs = 0; fails = 0;
        n_data = 0; n_dmrs = 0; n_done = 0;
        c_k0 = 0; c_m = 0; c_ss = 0; c_se = 0; c_dm = 0; c_bad = 1'b0;

        do_reset();
        do_reset();
        chk_en = 1'b1;
        idle();
        chk("reset data_valid", int'(data_valid), 0);
        chk("reset out_r", int'(out_r), 0);
        chk("reset slot_done", int'(slot_done), 0);

        // Full band with in_valid toggling, cut by reset at bin 700 of symbol 3.
        do_start(424, 100, 0, 13, 2);
        run_slot(1'b1, 99, 0, 3, 700);
        do_reset();
        idle();
        idle();
        chk("gap data count", n_data, 2676);
        chk("gap dmrs count", n_dmrs, 1200);
        chk("gap record count", rec_q.size(), 3876);
        chk("post-reset out_r", int'(out_r), 0);
        chk("post-reset out_i", int'(out_i), 0);
        chk("post-reset out_sc_idx", int'(out_sc_idx), 0);
        chk("post-reset out_sym", int'(out_sym), 0);
        qb = rec_q;
        rec_q.delete();
        last_q.delete();
        b_data = n_data; b_dmrs = n_dmrs; b_done = n_done;

        // Full band, full slot, back-to-back bins.
        do_start(424, 100, 0, 13, 2);
        run_slot(1'b0, 99, 0, 99, 0);
        repeat (4) idle();
        chk("full dmrs count", n_dmrs - b_dmrs, 1200);
        chk("full data count", n_data - b_data, 15600);
        chk("full slot_done count", n_done - b_done, 1);
        chk("full first out_r", int'(rec_q[0].r), 424);
        chk("full first sc_idx", int'(rec_q[0].idx), 0);
        chk("full sym_last count", last_q.size(), 14);
        chk("full first sym_last out_r", last_q[0], 1623);
        bad = 0;
        for (int j = 0; j < qb.size(); j++) begin
            if (j >= rec_q.size() || qb[j] != rec_q[j]) bad++;
        end
        chk("gapped vs full sequence diffs", bad, 0);
        b_data = n_data; b_dmrs = n_dmrs; b_done = n_done;

        // Over-range allocation plus a mid-symbol resync in symbol 5.
        do_start(2000, 5, 0, 13, 2);
        idle();
        chk("cfg_err after latch", int'(cfg_err), 1);
        run_slot(1'b0, 5, 1000, 99, 0);
        repeat (4) idle();
        chk("cfg_err slot valids", (n_data - b_data) + (n_dmrs - b_dmrs), 0);
        chk("cfg_err slot_done count", n_done - b_done, 1);
        chk("sync_err sticky", int'(sync_err), 1);
        chk("cfg_err sticky", int'(cfg_err), 1);
        b_data = n_data; b_dmrs = n_dmrs;
        rec_q.delete();

        // One RB at bin 0, symbols 4..6 with DMRS in 5.
        do_start(0, 1, 4, 6, 5);
        idle();
        chk("cfg_err cleared", int'(cfg_err), 0);
        chk("sync_err cleared", int'(sync_err), 0);
        run_slot(1'b0, 99, 0, 7, 10);
        repeat (3) idle();
        chk("narrow data count", n_data - b_data, 24);
        chk("narrow dmrs count", n_dmrs - b_dmrs, 12);
        chk("narrow record count", rec_q.size(), 36);
        chk("narrow first sym", int'(rec_q[0].sym), 4);
        chk("narrow dmrs sym", int'(rec_q[12].sym), 5);
        chk("narrow dmrs flag", int'(rec_q[12].dm), 1);
        chk("narrow last sym", int'(rec_q[35].sym), 6);
        chk("narrow last idx", int'(rec_q[35].idx), 11);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/re_demapper.md
Name: re_demapper

Overview:
Receive-side resource element demapper, the inverse of the transmit resource element mapper. It consumes the frequency-domain output of the receive FFT, one 2048-bin OFDM symbol at a time, bin-ordered. It extracts the allocated subcarriers and routes them to either a DMRS stream (toward channel estimation) or a data stream (toward equalisation and demodulation). Out-of-band bins and unallocated symbols are dropped.

Parameters:
WIDTH, 26, bit width of each I/Q sample (signed).
NFFT, 2048, bins per OFDM symbol.
ADDR_W, 11, log2(NFFT); width of the bin and subcarrier counters.
SYM_PER_SLOT, 14, OFDM symbols per slot.

Ports:
clk  input  1  single clock for the entire block.
reset  input  1  synchronous, active-high reset.
slot_start  input  1  one-cycle pulse; latches config and starts a slot.
N_sc_start  input  11  first allocated bin k0; latched at slot_start.
N_rb  input  7  allocated RBs; M = 12*N_rb subcarriers; latched at slot_start.
Sym_Start  input  4  first PUSCH symbol index; latched at slot_start.
Sym_End  input  4  last PUSCH symbol index, inclusive; latched at slot_start.
Dmrs_sym  input  4  DMRS symbol index; latched at slot_start.
in_valid  input  1  input sample qualifier.
in_first  input  1  marks bin 0 of a symbol; meaningful only with in_valid.
in_r / in_i  input  WIDTH  FFT bin, signed.
data_valid  output  1  data-stream qualifier.
dmrs_valid  output  1  DMRS-stream qualifier.
out_r / out_i  output  WIDTH  selected sample; shared by both streams.
out_sc_idx  output  11  k - k0, range 0..M-1.
out_sym  output  4  symbol index of the current output.
sym_last  output  1  asserted with the valid at out_sc_idx = M-1.
slot_done  output  1  one-cycle pulse after the last bin of symbol 13.
cfg_err  output  1  sticky; cleared at slot_start.
sync_err  output  1  sticky; cleared at slot_start.

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- States:
  - IDLE: wait for slot_start.
  - WAIT_SYM: wait for in_valid & in_first.
  - RUN: count bins.
  - DONE: one cycle; drives slot_done=1, then goes to IDLE.
- slot_start in any state:
  - latch all config, clear both error flags, sym_cnt = 0, go to WAIT_SYM;
  - a sample presented in the same cycle is ignored; slot_start has priority.
- WAIT_SYM:
  - in_valid & in_first → bin_cnt = 0 is consumed, next state RUN, bin_cnt becomes 1;
  - in_valid without in_first → sample dropped, no error.
- RUN:
  - each in_valid increments bin_cnt; cycles with in_valid=0 hold all state, so gaps are allowed;
  - in_valid & in_first with bin_cnt != 0 → pulse-set sync_err, treat the sample as bin 0 of the same sym_cnt (symbol restarts; sym_cnt not advanced).
- Symbol end, on the bin with index NFFT-1:
  - if sym_cnt = SYM_PER_SLOT-1 → go to DONE;
  - otherwise sym_cnt++ and go to WAIT_SYM.
- Selection, for a sample at bin k in symbol l:
  - selected iff Sym_Start ≤ l ≤ Sym_End and k0 ≤ k ≤ k0+M-1;
  - l = Dmrs_sym → dmrs_valid; otherwise → data_valid;
  - never both asserted.
- Latency: exactly 1 cycle from the accepted input to registered outputs.
  - out_r/out_i equal in_r/in_i unmodified (no scaling, no sign change).
- Output hold: when both valids are 0, out_r/out_i/out_sc_idx hold their last values.
- Config check at latch; cfg_err = 1 if any of:
  - N_rb = 0;
  - k0 + 12*N_rb > NFFT (computed 12 bits wide, no wrap);
  - Sym_Start > Sym_End;
  - Sym_End ≥ SYM_PER_SLOT.
- With cfg_err set:
  - counting and slot_done proceed normally;
  - data_valid and dmrs_valid are forced to 0 for the slot.
- Dmrs_sym outside [Sym_Start, Sym_End] is legal: no DMRS is output for that slot.
- Synchronous reset mid-operation: next edge returns the block to the reset state; outputs are 0 and the partial symbol is discarded.

Test Plan:
- Full band, N_sc_start=424, N_rb=100, Sym 0..13, Dmrs_sym=2, 14×2048 bins with in_r=bin index:
  - 1200 dmrs_valid in symbol 2;
  - 15600 data_valid total;
  - first output out_r=424 with out_sc_idx=0;
  - sym_last at out_r=1623;
  - slot_done exactly once, 1 cycle after the final bin.
- Same config with in_valid toggling 1/0 every cycle → identical output sequence; only the timing is stretched.
- in_first re-asserted at bin 1000 of symbol 5 → sync_err=1; symbol 5 restarts from bin 0; 14 symbols still complete and slot_done fires.
- N_sc_start=2000, N_rb=5 (2060 > 2048) → cfg_err=1; zero valids for the slot; slot_done still pulses.
- Sym_Start=4, Sym_End=6, Dmrs_sym=5, N_rb=1, N_sc_start=0 → 12 data in sym 4, 12 dmrs in sym 5, 12 data in sym 6; nothing else.
- reset at bin 700 of symbol 3, then a new slot_start → all outputs 0 after reset; the new slot runs cleanly from symbol 0.
